// File: rtl/ps2_host_tx_if.sv
// CPU-side command/status bundle for the PS/2 host transmitter.
// The master drives a byte request; the slave (transmitter) reports progress and result.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       error;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, busy, done, ack_ok, error
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, busy, done, ack_ok, error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK capture.
// Define PS2_HOST_TX_RETRY_EN to retry a NACKed or timed-out byte up to 3 times.
module ps2_host_tx #(
    parameter int unsigned InhibitCycles = 10000,
    parameter int unsigned TimeoutCycles = 1500000,
    parameter int unsigned SyncStages    = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    ps2_host_tx_if.slave tx_if,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe_o,
    output logic         ps2_data_oe_o
);

    localparam int unsigned InhW = (InhibitCycles > 1) ? $clog2(InhibitCycles) : 1;
    localparam int unsigned ToW  = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {StIdle, StInhibit, StXfer, StAck, StWaitIdle} state_e;

    state_e                state_q, state_d;
    logic [SyncStages-1:0] clk_sync_q, data_sync_q;
    logic                  clk_prev_q;
    logic [InhW-1:0]       inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]        to_cnt_q, to_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [9:0]            shift_q, shift_d;
    logic                  clk_oe_q, clk_oe_d;
    logic                  data_oe_q, data_oe_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  ack_ok_q, ack_ok_d;
    logic                  ack_int_q, ack_int_d;

    logic clk_s, data_s, clk_fall, accept, timeout, restart, retry_ok;

    assign clk_s    = clk_sync_q[SyncStages-1];
    assign data_s   = data_sync_q[SyncStages-1];
    assign clk_fall = clk_prev_q & ~clk_s;
    assign accept   = tx_if.tx_valid && (state_q == StIdle);
    assign timeout  = (state_q inside {StXfer, StAck, StWaitIdle}) &&
                      (to_cnt_q == ToW'(TimeoutCycles - 1));

`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0] retry_cnt_q, retry_cnt_d;

    assign retry_ok = (retry_cnt_q != 2'd3);

    always_comb begin
        retry_cnt_d = retry_cnt_q;
        if (accept) begin
            retry_cnt_d = '0;
        end else if (restart) begin
            retry_cnt_d = retry_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retry_cnt_q <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        ack_ok_d  = ack_ok_q;
        ack_int_d = ack_int_q;
        restart   = 1'b0;

        if (state_q inside {StXfer, StAck, StWaitIdle}) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d   = {1'b1, ~^tx_if.tx_data, tx_if.tx_data};
                    state_d   = StInhibit;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    inh_cnt_d = '0;
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhW'(InhibitCycles - 1)) begin
                    // Start bit and clock release together form the request-to-send.
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = StXfer;
                end else begin
                    inh_cnt_d = inh_cnt_q + InhW'(1);
                end
            end
            StXfer: begin
                if (clk_fall) begin
                    // shift_q[9] is the stop bit, so edge 10 releases the line.
                    data_oe_d = ~shift_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                if (clk_fall) begin
                    ack_int_d = ~data_s;
                    state_d   = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_s && data_s) begin
                    if (!ack_int_q && retry_ok) begin
                        restart = 1'b1;
                    end else begin
                        done_d   = 1'b1;
                        ack_ok_d = ack_int_q;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            ack_ok_d  = ack_ok_q;
            ack_int_d = ack_int_q;
            if (retry_ok) begin
                restart = 1'b1;
            end else begin
                error_d = 1'b1;
                state_d = StIdle;
            end
        end

        if (restart) begin
            state_d   = StInhibit;
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            inh_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= StIdle;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ack_ok_q    <= 1'b0;
            ack_int_q   <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SyncStages-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SyncStages-2:0], ps2_data_i};
            clk_prev_q  <= clk_s;
            state_q     <= state_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ack_ok_q    <= ack_ok_d;
            ack_int_q   <= ack_int_d;
        end
    end

    assign tx_if.tx_ready = (state_q == StIdle);
    assign tx_if.busy     = (state_q != StIdle);
    assign tx_if.done     = done_q;
    assign tx_if.ack_ok   = ack_ok_q;
    assign tx_if.error    = error_q;
    assign ps2_clk_oe_o   = clk_oe_q;
    assign ps2_data_oe_o  = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends command bytes to the keyboard on the IO[8]/IO[9] PS/2 pair: LED set 0xED, enable 0xF4, reset 0xFF.
- Complements the existing PS/2 receive path, which handles device-to-host traffic.
- Drives both lines open-drain through output-enable signals; the top level ties them to IO with pullups.
- Reports completion, device ACK and errors to the CPU-side peripheral register block.

Parameters:
- INHIBIT_CYCLES, 10000: clocks the host holds ps2 clock low before requesting to send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clocks from request-to-send until the ACK phase completes (15 ms).
- SYNC_STAGES, 2: synchronizer depth on ps2_clk_i and ps2_data_i; must be ≥2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  byte to send
- tx_ready  out  1  block idle; byte accepted when tx_valid && tx_ready
- busy  out  1  transfer in progress; the receiver ignores the bus while high
- done  out  1  one-cycle pulse at the end of a successful or NACKed transfer
- ack_ok  out  1  valid with done: 1 = device ACKed (data low at ACK edge)
- error  out  1  one-cycle pulse on timeout
- ps2_clk_i  in  1  PS/2 clock line sense
- ps2_data_i  in  1  PS/2 data line sense
- ps2_clk_oe  out  1  1 = pull clock line low
- ps2_data_oe  out  1  1 = pull data line low

Behaviour:
- Reset values:
  - tx_ready = 1; busy, done, ack_ok, error = 0.
  - ps2_clk_oe = 0, ps2_data_oe = 0 (both lines released).
  - State IDLE; all counters 0.
- Input conditioning:
  - Both line inputs pass through SYNC_STAGES flops.
  - A falling edge is registered synchronized-previous = 1 and synchronized-current = 0.
- On acceptance, latch the shift register {stop=1, parity, tx_data}.
  - parity = ~^tx_data (odd parity).
- IDLE: tx_ready = 1. On accept, go to INHIBIT, set tx_ready = 0 and busy = 1.
- INHIBIT:
  - ps2_clk_oe = 1; count INHIBIT_CYCLES.
  - At the terminal count: ps2_data_oe = 1 (start bit) and ps2_clk_oe = 0 on the same cycle; go to XFER.
  - The timeout counter clears and starts on this transition.
- XFER: on each synchronized clock falling edge, set bit_cnt += 1.
  - Edges 1..8: ps2_data_oe = ~tx_data[bit_cnt-1], LSB first.
  - Edge 9: ps2_data_oe = ~parity.
  - Edge 10: ps2_data_oe = 0 (stop bit, line released). Go to ACK.
  - The data change takes effect on the cycle after the edge is detected.
- ACK: on the next falling edge, capture ack_ok_int = ~data_sync and go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until both synchronized lines are high.
  - Then pulse done with ack_ok = ack_ok_int, clear busy, set tx_ready = 1, return to IDLE.
  - ack_ok holds its value until the next done.
- Timeout, checked in XFER, ACK and WAIT_IDLE:
  - If the counter reaches TIMEOUT_CYCLES, release both lines in the same cycle.
  - Pulse error, clear busy, set tx_ready = 1, go to IDLE. done is not pulsed.
- Line contention:
  - A device-initiated frame present before or at accept does not block. The host-inhibit overrides it; this is allowed by the protocol.
  - The receiver must discard its partial frame while busy = 1.
- tx_valid while busy is ignored; no queueing.
- If reset_n asserts mid-transfer, both oe outputs deassert immediately (asynchronous). No done or error pulse is produced.
- Simultaneous events: if a timeout coincides with the ACK-capture edge, timeout wins.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - A NACK (ack_ok_int = 0) or a timeout restarts from INHIBIT with the same latched byte.
  - At most 3 retries are made. A retry counter clears on accept.
  - done/ack_ok or error is reported only for the final attempt.
  - busy stays high across retries.
- Undefined: single attempt; behaviour exactly as described in Behaviour.

Test Plan (INHIBIT_CYCLES=100, TIMEOUT_CYCLES=20000; device model clocks with a 60 us period and samples data on rising edges):
- Send 0xED, device ACKs -> device receives start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. done=1 for one cycle, ack_ok=1. ps2_clk_oe was high for exactly 100 cycles.
- Send 0xF4, device ACKs -> parity bit 0. done with ack_ok=1. tx_ready returns to 1 only after both lines are high.
- Send 0x00, device leaves data high at the ACK clock -> parity 1 observed. done with ack_ok=0. Without the macro, no retry occurs.
- Send 0xFF, device never clocks -> after 20000 cycles, error pulses once, both oe=0, done never asserts, tx_ready=1.
- Assert tx_valid with 0xAA during a transfer of 0xED -> ignored; only 0xED appears on the bus.
- Assert reset_n low after edge 4 of a transfer -> both oe=0 immediately. After release, tx_ready=1 and the next send of 0xF4 completes normally.
- With PS2_HOST_TX_RETRY_EN, the device NACKs twice then ACKs -> 3 frames are observed on the bus, a single done with ack_ok=1, and busy is continuous across all three.
